// File: rtl/alphamission_sprite_line_buffer.sv
// Ping-pong sprite line buffer: the renderer fills the draw bank while the display
// bank streams out as LD and is erased behind the beam; a post-reset sequencer clears both banks.
module alphamission_sprite_line_buffer #(
    parameter int unsigned   AW     = 8,
    parameter int unsigned   DW     = 8,
    parameter logic [DW-1:0] TRANSP = 8'hFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_cen,
    input  logic          line_swap,
    input  logic [AW-1:0] hcount,
    input  logic          flip,
    input  logic          clr_en,
    input  logic          spr_wr,
    input  logic [AW-1:0] spr_x,
    input  logic [DW-1:0] spr_d,
    output logic [DW-1:0] LD,
    output logic          bank_sel,
    output logic          init_busy,
    output logic          wr_dropped
);

    localparam int unsigned   DEPTH     = 2 ** AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t state, state_next;

    logic [AW-1:0] init_cnt;
    logic [DW-1:0] bank0 [0:DEPTH-1];
    logic [DW-1:0] bank1 [0:DEPTH-1];

    logic          in_init;
    logic          in_run;
    logic [AW-1:0] raddr;
    logic          erase;
    logic          draw_wr;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: INIT walks every address once, then RUN until reset
    always_comb begin
        state_next = state;
        case (state)
            S_INIT:  if (init_cnt == LAST_ADDR) state_next = S_RUN;
            S_RUN:   state_next = S_RUN;
            default: state_next = S_INIT;
        endcase
    end

    // Output logic: per-bank write port selection from the current bank roles
    always_comb begin
        in_init = 1'b0;
        in_run  = 1'b0;
        case (state)
            S_INIT:  in_init = 1'b1;
            S_RUN:   in_run  = 1'b1;
            default: in_init = 1'b1;
        endcase

        raddr   = flip ? ~hcount : hcount;
        erase   = in_run & pix_cen & clr_en;
        draw_wr = in_run & spr_wr & (spr_d[3:0] != TRANSP[3:0]);

        we0    = 1'b0;
        addr0  = init_cnt;
        wdata0 = TRANSP;
        we1    = 1'b0;
        addr1  = init_cnt;
        wdata1 = TRANSP;

        if (in_init) begin
            we0 = 1'b1;
            we1 = 1'b1;
        end else if (!bank_sel) begin
            // bank0 on display, bank1 drawing
            we0    = erase;
            addr0  = raddr;
            we1    = draw_wr;
            addr1  = spr_x;
            wdata1 = spr_d;
        end else begin
            we1    = erase;
            addr1  = raddr;
            we0    = draw_wr;
            addr0  = spr_x;
            wdata0 = spr_d;
        end
    end

    // Bank storage; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we0) bank0[addr0] <= wdata0;
        if (we1) bank1[addr1] <= wdata1;
    end

    // Control registers and the registered pixel output (read returns pre-erase data)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt   <= '0;
            init_busy  <= 1'b1;
            wr_dropped <= 1'b0;
            bank_sel   <= 1'b0;
            LD         <= TRANSP;
        end else begin
            init_cnt   <= in_init ? init_cnt + AW'(1) : '0;
            init_busy  <= (state_next == S_INIT);
            wr_dropped <= in_init & spr_wr;
            if (in_run && line_swap) bank_sel <= ~bank_sel;
            if (in_run && pix_cen) begin
                LD <= bank_sel ? bank1[raddr] : bank0[raddr];
            end else if (in_init) begin
                LD <= TRANSP;
            end
        end
    end

endmodule

// File: tb/tb_alphamission_sprite_line_buffer.sv
// Directed bench for the sprite line buffer: a per-clock behavioural model is compared
// with every output each cycle, plus hand-computed pixel expectations.
module tb_alphamission_sprite_line_buffer;

    logic       clk;
    logic       rst;
    logic       pix_cen;
    logic       line_swap;
    logic [7:0] hcount;
    logic       flip;
    logic       clr_en;
    logic       spr_wr;
    logic [7:0] spr_x;
    logic [7:0] spr_d;
    logic [7:0] LD;
    logic       bank_sel;
    logic       init_busy;
    logic       wr_dropped;

    int vectors     = 0;
    int miscompares = 0;

    alphamission_sprite_line_buffer #(.AW(8), .DW(8), .TRANSP(8'hFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_cen    (pix_cen),
        .line_swap  (line_swap),
        .hcount     (hcount),
        .flip       (flip),
        .clr_en     (clr_en),
        .spr_wr     (spr_wr),
        .spr_x      (spr_x),
        .spr_d      (spr_d),
        .LD         (LD),
        .bank_sel   (bank_sel),
        .init_busy  (init_busy),
        .wr_dropped (wr_dropped)
    );

    always #5 clk = ~clk;

    // Behavioural model: two plain arrays of pixels and which one is on screen
    logic [7:0] m_mem [2][256];
    int         m_cnt;
    int         m_a;
    bit         m_init;
    bit         m_sel;
    bit         m_drop;
    logic [7:0] m_ld;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_init = 1'b1;
            m_cnt  = 0;
            m_sel  = 1'b0;
            m_drop = 1'b0;
            m_ld   = 8'hFF;
        end else if (m_init) begin
            m_mem[0][m_cnt] = 8'hFF;
            m_mem[1][m_cnt] = 8'hFF;
            m_drop = spr_wr;
            m_cnt++;
            if (m_cnt == 256) m_init = 1'b0;
        end else begin
            m_drop = 1'b0;
            if (pix_cen) begin
                m_a  = flip ? 255 - int'(hcount) : int'(hcount);
                m_ld = m_mem[m_sel][m_a];
                if (clr_en) m_mem[m_sel][m_a] = 8'hFF;
            end
            if (spr_wr && (int'(spr_d) % 16) != 15) m_mem[!m_sel][spr_x] = spr_d;
            if (line_swap) m_sel = !m_sel;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("LD",         int'(LD),         int'(m_ld));
        chk("bank_sel",   int'(bank_sel),   int'(m_sel));
        chk("init_busy",  int'(init_busy),  int'(m_init));
        chk("wr_dropped", int'(wr_dropped), int'(m_drop));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr_px(input logic [7:0] x, input logic [7:0] d);
        spr_wr = 1'b1; spr_x = x; spr_d = d;
        tick();
        spr_wr = 1'b0;
    endtask

    task automatic swap_line();
        line_swap = 1'b1;
        tick();
        line_swap = 1'b0;
    endtask

    task automatic read_px(input logic [7:0] h, input bit clr);
        pix_cen = 1'b1; hcount = h; clr_en = clr;
        tick();
        pix_cen = 1'b0; clr_en = 1'b0;
    endtask

    task automatic count_init(output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        clk = 1'b0; rst = 1'b0;
        pix_cen = 1'b0; line_swap = 1'b0; hcount = '0; flip = 1'b0;
        clr_en = 1'b0; spr_wr = 1'b0; spr_x = '0; spr_d = '0;
        #1 rst = 1'b1;
        tick();
        chk("rst_ld",   int'(LD),        8'hFF);
        chk("rst_busy", int'(init_busy), 1);
        #1 rst = 1'b0;

        count_init(n);
        chk("init_len", n, 256);

        // Both banks read back as transparent after the clear
        for (int i = 0; i < 256; i++) begin
            read_px(8'(i), 1'b0);
            chk("init_rd0", int'(LD), 8'hFF);
        end
        swap_line();
        for (int i = 0; i < 256; i++) begin
            read_px(8'(i), 1'b0);
            chk("init_rd1", int'(LD), 8'hFF);
        end

        // Write, swap, read
        wr_px(8'd10, 8'h23);
        swap_line();
        read_px(8'd10, 1'b0);
        chk("rd_x10", int'(LD), 8'h23);
        read_px(8'd11, 1'b0);
        chk("rd_x11", int'(LD), 8'hFF);

        // Transparent pen and last-opaque-wins
        wr_px(8'd5, 8'h41);
        wr_px(8'd5, 8'h3F);
        wr_px(8'd6, 8'h12);
        wr_px(8'd6, 8'h57);
        swap_line();
        read_px(8'd5, 1'b0);
        chk("prio_x5", int'(LD), 8'h41);
        read_px(8'd6, 1'b0);
        chk("prio_x6", int'(LD), 8'h57);

        // Erase behind the beam (x=10 lives in the other bank)
        swap_line();
        read_px(8'd10, 1'b1);
        chk("erase_rd", int'(LD), 8'h23);
        swap_line();
        swap_line();
        read_px(8'd10, 1'b0);
        chk("erase_gone", int'(LD), 8'hFF);

        // Without erase the pixel survives two swaps
        wr_px(8'd12, 8'h23);
        swap_line();
        read_px(8'd12, 1'b0);
        chk("keep_rd", int'(LD), 8'h23);
        swap_line();
        swap_line();
        read_px(8'd12, 1'b0);
        chk("keep_again", int'(LD), 8'h23);

        // Flip mirrors the read address
        wr_px(8'h02, 8'h66);
        swap_line();
        flip = 1'b1;
        read_px(8'hFD, 1'b0);
        chk("flip_rd", int'(LD), 8'h66);
        flip = 1'b0;

        // Write coinciding with swap lands on the line now being displayed;
        // the coinciding read still uses the old display bank
        spr_wr = 1'b1; spr_x = 8'd20; spr_d = 8'h77;
        line_swap = 1'b1; pix_cen = 1'b1; hcount = 8'h02;
        tick();
        spr_wr = 1'b0; line_swap = 1'b0; pix_cen = 1'b0;
        chk("coll_old", int'(LD), 8'h66);
        read_px(8'd20, 1'b0);
        chk("coll_new", int'(LD), 8'h77);

        // Reset in the middle of INIT restarts the full clear
        #1 rst = 1'b1;
        tick();
        #1 rst = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        #1 rst = 1'b1;
        tick();
        chk("midrst_busy", int'(init_busy), 1);
        #1 rst = 1'b0;
        spr_wr = 1'b1; spr_x = 8'd3; spr_d = 8'h11; line_swap = 1'b1;
        tick();
        spr_wr = 1'b0; line_swap = 1'b0;
        chk("drop_pulse", int'(wr_dropped), 1);
        chk("swap_ignored", int'(bank_sel), 0);
        count_init(n);
        chk("midrst_len", n + 1, 256);
        tick();
        chk("drop_clear", int'(wr_dropped), 0);
        read_px(8'd3, 1'b0);
        chk("drop_nowrite", int'(LD), 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
